// File: rtl/bcd_to_xs3_serial.sv
// Serial BCD -> Excess-3 converter, LSB first, 4-bit frames, Mealy adder of 0011.
// Define BCD2XS3_REG_OUT_EN to register Z/Last/Err (one cycle later, cleared on reset).
module bcd_to_xs3_serial #(
    parameter bit CHECK_INVALID = 1'b1
) (
    input  logic Clk,
    input  logic Rst,
    input  logic X,
    output logic Z,
    output logic Last,
    output logic Err
);

    // State name = bit position within the digit plus the running carry.
    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1C0 = 3'd1,
        S1C1 = 3'd2,
        S2C0 = 3'd3,
        S2C1 = 3'd4,
        S3C0 = 3'd5,
        S3C1 = 3'd6
    } state_e;

    state_e state_q, state_d;
    logic   hi_q, hi_d;
    logic   z_c, last_c, err_c;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S0;
            hi_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
        end
    end

    always_comb begin
        state_d = S0;
        hi_d    = hi_q;
        z_c     = ~X;
        last_c  = 1'b0;
        err_c   = 1'b0;
        unique case (state_q)
            S0: begin
                z_c     = ~X;
                hi_d    = 1'b0;
                state_d = X ? S1C1 : S1C0;
            end
            S1C0: begin
                z_c     = ~X;
                hi_d    = X;
                state_d = X ? S2C1 : S2C0;
            end
            S1C1: begin
                z_c     = X;
                hi_d    = X;
                state_d = S2C1;
            end
            S2C0: begin
                z_c     = X;
                hi_d    = hi_q | X;
                state_d = S3C0;
            end
            S2C1: begin
                z_c     = ~X;
                hi_d    = hi_q | X;
                state_d = X ? S3C1 : S3C0;
            end
            S3C0: begin
                z_c     = X;
                last_c  = 1'b1;
                err_c   = CHECK_INVALID & X & hi_q;
                state_d = S0;
            end
            S3C1: begin
                z_c     = ~X;
                last_c  = 1'b1;
                err_c   = CHECK_INVALID & X & hi_q;
                state_d = S0;
            end
            default: begin
                state_d = S0;
            end
        endcase
        // During reset the digit restarts: bit-0 Mealy value, no flags.
        if (Rst) begin
            state_d = S0;
            hi_d    = 1'b0;
            z_c     = ~X;
            last_c  = 1'b0;
            err_c   = 1'b0;
        end
    end

`ifdef BCD2XS3_REG_OUT_EN
    logic z_q, last_q, err_q;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            z_q    <= 1'b0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            z_q    <= z_c;
            last_q <= last_c;
            err_q  <= err_c;
        end
    end

    assign Z    = z_q;
    assign Last = last_q;
    assign Err  = err_q;
`else
    assign Z    = z_c;
    assign Last = last_c;
    assign Err  = err_c;
`endif

endmodule

// File: tb/tb_bcd_to_xs3_serial.sv
// Bench for bcd_to_xs3_serial: directed spec vectors plus random digits against an
// arithmetic reference model; covers both CHECK_INVALID settings side by side.
module tb_bcd_to_xs3_serial;

`ifdef BCD2XS3_REG_OUT_EN
    localparam int unsigned LAT = 1;
`else
    localparam int unsigned LAT = 0;
`endif

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    logic X   = 1'b0;
    logic z1, l1, e1;
    logic z0, l0, e0;

    bcd_to_xs3_serial #(.CHECK_INVALID(1'b1)) dut_chk (
        .Clk(Clk), .Rst(Rst), .X(X), .Z(z1), .Last(l1), .Err(e1)
    );

    bcd_to_xs3_serial #(.CHECK_INVALID(1'b0)) dut_nochk (
        .Clk(Clk), .Rst(Rst), .X(X), .Z(z0), .Last(l0), .Err(e0)
    );

    always #5 Clk = ~Clk;

    int tests = 0;
    int fails = 0;

    // Reference model: partial digit value and bit position, plus output pipeline.
    int m_pos = 0;
    int m_val = 0;
    bit pz = 1'b0, pl = 1'b0, pe = 1'b0;
    bit exp_z, exp_l, exp_e;

    task automatic apply(input bit x, input bit rst);
        bit cz, cl, ce;
        int dv;
        @(negedge Clk);
        X   = x;
        Rst = rst;
        #1;
        if (rst) begin
            cz = ~x; cl = 1'b0; ce = 1'b0;
            m_pos = 0; m_val = 0;
        end else begin
            dv = m_val + (int'(x) << m_pos);
            // Low bits of (d+3) depend only on the low bits of d seen so far.
            cz = bit'(((dv + 3) >> m_pos) & 1);
            cl = (m_pos == 3);
            ce = (m_pos == 3) && (dv > 9);
            if (m_pos == 3) begin
                m_pos = 0; m_val = 0;
            end else begin
                m_pos = m_pos + 1; m_val = dv;
            end
        end
        if (LAT == 1) begin
            exp_z = pz; exp_l = pl; exp_e = pe;
            pz = rst ? 1'b0 : cz;
            pl = rst ? 1'b0 : cl;
            pe = rst ? 1'b0 : ce;
        end else begin
            exp_z = cz; exp_l = cl; exp_e = ce;
        end
    endtask

    task automatic test_reset();
        apply(1'b0, 1'b1);
        apply(1'b1, 1'b1);
        tests++;
        if (z1 !== exp_z) begin fails++; $display("FAIL reset_z got=%b exp=%b", z1, exp_z); end
        tests++;
        if (l1 !== 1'b0) begin fails++; $display("FAIL reset_last got=%b exp=0", l1); end
        tests++;
        if (e1 !== 1'b0) begin fails++; $display("FAIL reset_err got=%b exp=0", e1); end
        tests++;
        if (l0 !== 1'b0 || e0 !== 1'b0) begin
            fails++; $display("FAIL reset_nochk got=%b%b exp=00", l0, e0);
        end
    endtask

    task automatic test_digits();
        logic [3:0] digs  [4] = '{4'd5, 4'd0, 4'd9, 4'd10};
        logic [3:0] zexp  [4] = '{4'b1000, 4'b0011, 4'b1100, 4'b1101};
        logic [3:0] eexp  [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000};
        logic [7:0] zs, ls, es;
        logic [3:0] d;
        for (int k = 0; k < 4; k++) begin
            d = digs[k];
            for (int b = 0; b < 8; b++) begin
                apply((b < 4) ? d[b] : 1'b0, 1'b0);
                zs[b] = z1; ls[b] = l1; es[b] = e1;
                tests++;
                if (z1 !== exp_z || l1 !== exp_l || e1 !== exp_e || e0 !== 1'b0) begin
                    fails++;
                    $display("FAIL digit%0d_bit%0d got z/l/e/e0=%b%b%b%b exp=%b%b%b0",
                             d, b, z1, l1, e1, e0, exp_z, exp_l, exp_e);
                end
            end
            tests++;
            if (zs[LAT +: 4] !== zexp[k]) begin
                fails++; $display("FAIL digit%0d_xs3 got=%b exp=%b", d, zs[LAT +: 4], zexp[k]);
            end
            tests++;
            if (ls[LAT +: 4] !== 4'b1000) begin
                fails++; $display("FAIL digit%0d_last got=%b exp=1000", d, ls[LAT +: 4]);
            end
            tests++;
            if (es[LAT +: 4] !== eexp[k]) begin
                fails++; $display("FAIL digit%0d_err got=%b exp=%b", d, es[LAT +: 4], eexp[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] zs, ls;
        logic [3:0] two = 4'd2;
        apply(1'b1, 1'b0);
        apply(1'b1, 1'b0);
        apply(1'($urandom_range(0, 1)), 1'b1);
        tests++;
        if (z1 !== exp_z || l1 !== exp_l || e1 !== exp_e) begin
            fails++; $display("FAIL midrst_cycle got=%b%b%b exp=%b%b%b", z1, l1, e1, exp_z, exp_l, exp_e);
        end
        for (int b = 0; b < 8; b++) begin
            apply((b < 4) ? two[b] : 1'b0, 1'b0);
            zs[b] = z1; ls[b] = l1;
            tests++;
            if (z1 !== exp_z || l1 !== exp_l || e1 !== exp_e) begin
                fails++;
                $display("FAIL midrst_bit%0d got=%b%b%b exp=%b%b%b", b, z1, l1, e1, exp_z, exp_l, exp_e);
            end
        end
        tests++;
        if (zs[LAT +: 4] !== 4'b0101) begin
            fails++; $display("FAIL midrst_xs3 got=%b exp=0101", zs[LAT +: 4]);
        end
        tests++;
        if (ls[LAT +: 4] !== 4'b1000) begin
            fails++; $display("FAIL midrst_last got=%b exp=1000", ls[LAT +: 4]);
        end
    endtask

    task automatic test_back_to_back();
        logic [43:0] zs, ls;
        logic [3:0] d;
        for (int c = 0; c < 44; c++) begin
            d = (c < 40) ? 4'(c / 4) : 4'd0;
            apply(d[c % 4], 1'b0);
            zs[c] = z1; ls[c] = l1;
            tests++;
            if (z1 !== exp_z || l1 !== exp_l || e1 !== exp_e) begin
                fails++;
                $display("FAIL b2b_cycle%0d got=%b%b%b exp=%b%b%b", c, z1, l1, e1, exp_z, exp_l, exp_e);
            end
        end
        for (int k = 0; k < 10; k++) begin
            tests++;
            if (zs[k*4 + LAT +: 4] !== 4'(k + 3) || ls[k*4 + LAT +: 4] !== 4'b1000) begin
                fails++;
                $display("FAIL b2b_digit%0d got z=%b last=%b exp z=%b last=1000",
                         k, zs[k*4 + LAT +: 4], ls[k*4 + LAT +: 4], 4'(k + 3));
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        int rpos;
        for (int n = 0; n < 10000; n++) begin
            d    = 4'($urandom_range(0, 15));
            rpos = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            for (int b = 0; b < 4; b++) begin
                apply((b == rpos) ? 1'($urandom_range(0, 1)) : d[b], b == rpos);
                tests++;
                if (z1 !== exp_z || l1 !== exp_l || e1 !== exp_e) begin
                    fails++;
                    $display("FAIL rand_chk n=%0d b=%0d got=%b%b%b exp=%b%b%b",
                             n, b, z1, l1, e1, exp_z, exp_l, exp_e);
                end
                tests++;
                if (z0 !== exp_z || l0 !== exp_l || e0 !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_nochk n=%0d b=%0d got=%b%b%b exp=%b%b0",
                             n, b, z0, l0, e0, exp_z, exp_l);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
